jam_cost_server: RTL and testbench
==================================

// Module: jam_cost_server
// PURPOSE
//  Responder side of the job-assignment cost-lookup interface. Stores an N x N worker/job
//  cost table, answers (W,J) lookups with Cost combinationally, holds the assignment
//  engine in reset until the table is loaded, and captures the engine's final result.
//  Sits between the table loader (host stream) and the assignment engine.
// PARAMETERS
//  N        8   workers = jobs; index width IDX_W = clog2(N) = 3
//  COST_W   7   width of one cost entry
//  HOLD_CYC 2   cycles jam_rst stays high after the last table word
//  CNT_W    20  lookup-counter width (JAM_LOOKUP_CNT_EN only)
// PORTS
//  CLK         in   1       clock, rising edge
//  RST         in   1       synchronous, active-high reset
//  ld_valid    in   1       load word valid
//  ld_ready    out  1       load word accepted when ld_valid & ld_ready
//  ld_data     in   COST_W  cost word, row-major: word k -> W = k/N, J = k%N
//  jam_rst     out  1       reset to the assignment engine (active-high)
//  W           in   IDX_W   worker index from engine
//  J           in   IDX_W   job index from engine
//  Cost        out  COST_W  table[W][J], combinational from W,J
//  Valid       in   1       engine result strobe
//  MinCost     in   10      engine minimum cost
//  MatchCount  in   4       engine match count
//  done        out  1       result captured
//  res_min     out  10      captured MinCost
//  res_cnt     out  4       captured MatchCount
//  lookup_cnt  out  CNT_W   lookups served (JAM_LOOKUP_CNT_EN only)
// BEHAVIOUR
//  Reset values: ld_ready=1, jam_rst=1, Cost=0, done=0, res_min=0, res_cnt=0, lookup_cnt=0.
//  Table storage is not reset; a full reload is required after every RST.
//  FSM: LOAD -> HOLD -> RUN -> DONE; RST from any state -> LOAD, addr=0, hold_cnt=0.
//  LOAD: ld_ready=1. Each handshake writes table[addr] and increments the 6-bit addr.
//        The handshake with addr==N*N-1 moves to HOLD; addr wraps to 0.
//        ld_valid=0 stalls the load with no timeout.
//  HOLD: ld_ready=0, jam_rst=1 for exactly HOLD_CYC cycles, then -> RUN.
//  RUN:  jam_rst=0. Cost = table[W*N+J], same-cycle (zero latency), every cycle in RUN.
//        Valid=1 -> next edge: res_min<=MinCost, res_cnt<=MatchCount, done<=1, -> DONE.
//  DONE: jam_rst=1, ld_ready=0, Cost=0. Outputs hold until RST.
//  Cost is forced to 0 outside RUN.
//  Inputs ignored when not applicable: ld_valid outside LOAD; Valid outside RUN; W/J outside RUN.
//  The first Valid in RUN is captured; no later Valid is seen because the FSM leaves RUN.
//  Widths: address = {W,J} concatenation (N power of two); no arithmetic on Cost.
//  RST mid-LOAD discards partial progress (addr=0). RST mid-RUN discards the run
//  (done=0, jam_rst=1).
// CONFIGURATION
//  JAM_LOOKUP_CNT_EN defined:
//   - lookup_cnt increments by 1 each RUN cycle and saturates at 2^CNT_W-1.
//   - lookup_cnt freezes in DONE; RST clears it.
//  JAM_LOOKUP_CNT_EN undefined:
//   - lookup_cnt port and counter are absent.
//   - all other behaviour is identical.
// TESTING
//  1. Reset: RST=1 for 2 cycles -> ld_ready=1, jam_rst=1, Cost=0, done=0.
//  2. Load table[k]=k (k=0..63), back-to-back ld_valid=1:
//     -> ld_ready drops after word 63; jam_rst=1 for 2 more cycles, then 0.
//     Then W=3,J=5 -> Cost=29 in the same cycle; W=7,J=7 -> Cost=63; W=0,J=0 -> Cost=0.
//  3. Load with ld_valid toggling 1/0 every cycle -> all 64 words stored correctly;
//     spot-check W=6,J=1 -> 49.
//  4. In RUN, drive Valid=1 with MinCost=10'd312, MatchCount=4'd3:
//     -> next cycle done=1, res_min=312, res_cnt=3, jam_rst=1, Cost=0.
//     A later Valid with MinCost=5 leaves res_min at 312.
//  5. Reset mid-operation: RST after 20 loaded words -> ld_ready=1, addr restarts at 0,
//     and 64 more words are needed before jam_rst falls. RST in RUN -> done=0, jam_rst=1.
//  6. JAM_LOOKUP_CNT_EN: 100 RUN cycles then Valid -> lookup_cnt=100 and frozen in DONE;
//     without the macro the build has no lookup_cnt port.

Source files
------------

// File: rtl/jam_cost_server.sv
// Cost-table responder for the job-assignment engine: loads an N x N cost table, serves lookups, captures the result.
// Optional JAM_LOOKUP_CNT_EN adds a saturating count of RUN cycles on port lookup_cnt.
//
// state | meaning
// LOAD  | accepting table words, engine held in reset
// HOLD  | table complete, engine held in reset for HOLD_CYC more cycles
// RUN   | engine running, Cost answers lookups combinationally
// DONE  | result captured, engine back in reset until RST
module jam_cost_server #(
   parameter int N        = 8,
   parameter int COST_W   = 7,
   parameter int HOLD_CYC = 2,
`ifdef JAM_LOOKUP_CNT_EN
   parameter int CNT_W    = 20,
`endif
   localparam int IDX_W   = $clog2(N)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [COST_W-1:0] ld_data,
   output logic              jam_rst,
   input  logic [IDX_W-1:0]  W,
   input  logic [IDX_W-1:0]  J,
   output logic [COST_W-1:0] Cost,
   input  logic              Valid,
   input  logic [9:0]        MinCost,
   input  logic [3:0]        MatchCount,
   output logic [9:0]        res_min,
   output logic [3:0]        res_cnt,
`ifdef JAM_LOOKUP_CNT_EN
   output logic              done,
   output logic [CNT_W-1:0]  lookup_cnt
`else
   output logic              done
`endif
);

   localparam int ADDR_W = 2 * IDX_W;
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N * N - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [COST_W-1:0]   table_mem [N*N];
   logic                ld_fire;

   assign ld_fire = (state == S_LOAD) && ld_valid;

   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      jam_rst   = 1'b1;
      Cost      = '0;
      case (state)
         S_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid && (addr == ADDR_LAST)) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (hold_cnt == '0) state_nxt = S_RUN;
         end
         S_RUN: begin
            jam_rst = 1'b0;
            Cost    = table_mem[{W, J}];
            if (Valid) state_nxt = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_LOAD;
         addr     <= '0;
         hold_cnt <= '0;
         done     <= 1'b0;
         res_min  <= '0;
         res_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (ld_fire) addr <= addr + 1'b1;
         // hold timer counts down to terminal zero, loaded on the last table word
         if (ld_fire && (addr == ADDR_LAST)) hold_cnt <= HOLD_LOAD;
         else if ((state == S_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;
         if ((state == S_RUN) && Valid) begin
            done    <= 1'b1;
            res_min <= MinCost;
            res_cnt <= MatchCount;
         end
      end
   end

   // table storage is deliberately not reset; every RST is followed by a full reload
   always_ff @(posedge CLK) begin
      if (!RST && ld_fire) table_mem[addr] <= ld_data;
   end

`ifdef JAM_LOOKUP_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) lookup_cnt <= '0;
      else if ((state == S_RUN) && (lookup_cnt != '1)) lookup_cnt <= lookup_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized self-checking bench for jam_cost_server against a table/phase reference model.
module tb_jam_cost_server;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ld_valid;
   logic       ld_ready;
   logic [6:0] ld_data;
   logic       jam_rst;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic       Valid;
   logic [9:0] MinCost;
   logic [3:0] MatchCount;
   logic       done;
   logic [9:0] res_min;
   logic [3:0] res_cnt;
`ifdef JAM_LOOKUP_CNT_EN
   logic [19:0] lookup_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;
   int m_tab [64];
   int m_run = 0;

   always #5 CLK = ~CLK;

   jam_cost_server dut (
      .CLK        (CLK),
      .RST        (RST),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .jam_rst    (jam_rst),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .Valid      (Valid),
      .MinCost    (MinCost),
      .MatchCount (MatchCount),
      .res_min    (res_min),
      .res_cnt    (res_cnt),
`ifdef JAM_LOOKUP_CNT_EN
      .done       (done),
      .lookup_cnt (lookup_cnt)
`else
      .done       (done)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic noise();
      W          = 3'($urandom);
      J          = 3'($urandom);
      MinCost    = 10'($urandom);
      MatchCount = 4'($urandom);
   endtask

   task automatic do_reset();
      RST = 1'b1; ld_valid = 1'b0; Valid = 1'b0; noise();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      m_run = 0;
      #1;
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_jam_rst", jam_rst, 1);
      chk("rst_cost", Cost, 0);
      chk("rst_done", done, 0);
      chk("rst_res_min", res_min, 0);
      chk("rst_res_cnt", res_cnt, 0);
`ifdef JAM_LOOKUP_CNT_EN
      chk("rst_lookup_cnt", lookup_cnt, 0);
`endif
   endtask

   // mode 0: back-to-back random data; 1: valid toggles, data = index; 2: random gaps, random data
   task automatic load_table(input int mode);
      int  k = 0;
      int  cyc = 0;
      bit  tog = 1'b1;
      bit  v;
      logic [6:0] d;
      while (k < 64 && cyc < 1000) begin
         v   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
         tog = !tog;
         d   = (mode == 1) ? 7'(k) : 7'($urandom);
         ld_valid = v; ld_data = d; Valid = 1'($urandom_range(0, 1)); noise();
         #1;
         chk("load_ld_ready", ld_ready, 1);
         chk("load_jam_rst", jam_rst, 1);
         chk("load_cost", Cost, 0);
         chk("load_done", done, 0);
         @(posedge CLK); #1;
         if (v) begin
            m_tab[k] = int'(d);
            k++;
         end
         cyc++;
      end
      if (k < 64) chk("load_timeout", 0, 1);
      // engine stays in reset for two cycles; loader and result strobe are ignored meanwhile
      for (int h = 0; h < 2; h++) begin
         ld_valid = 1'b1; ld_data = 7'($urandom); Valid = 1'b1; noise();
         #1;
         chk("hold_ld_ready", ld_ready, 0);
         chk("hold_jam_rst", jam_rst, 1);
         chk("hold_cost", Cost, 0);
`ifdef JAM_LOOKUP_CNT_EN
         chk("hold_lookup_cnt", lookup_cnt, 0);
`endif
         @(posedge CLK); #1;
      end
      ld_valid = 1'b0; Valid = 1'b0;
      #1;
      chk("run_entry_jam_rst", jam_rst, 0);
      chk("run_entry_ld_ready", ld_ready, 0);
      chk("run_entry_done", done, 0);
   endtask

   task automatic partial_load(input int n);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1; ld_data = 7'($urandom);
         @(posedge CLK); #1;
      end
      ld_valid = 1'b0;
   endtask

   task automatic run_cycle(input logic [2:0] w, input logic [2:0] j);
      W = w; J = j; Valid = 1'b0;
      ld_valid = 1'($urandom_range(0, 1)); ld_data = 7'($urandom);
      #1;
      chk("run_cost", Cost, m_tab[int'(w) * 8 + int'(j)]);
      chk("run_jam_rst", jam_rst, 0);
      chk("run_done", done, 0);
`ifdef JAM_LOOKUP_CNT_EN
      chk("run_lookup_cnt", lookup_cnt, m_run);
`endif
      @(posedge CLK); #1;
      m_run++;
   endtask

   task automatic lookup_exp(input logic [2:0] w, input logic [2:0] j, input int exp_c);
      W = w; J = j;
      #1;
      chk("cost_fixed", Cost, exp_c);
      run_cycle(w, j);
   endtask

   task automatic run_lookups(input int n);
      for (int i = 0; i < n; i++) run_cycle(3'($urandom), 3'($urandom));
   endtask

   task automatic fire_valid(input logic [9:0] mc, input logic [3:0] mm);
      W = 3'($urandom); J = 3'($urandom);
      Valid = 1'b1; MinCost = mc; MatchCount = mm;
      #1;
      chk("valid_cycle_cost", Cost, m_tab[int'(W) * 8 + int'(J)]);
      @(posedge CLK); #1;
      m_run++;
      Valid = 1'b0; noise();
      #1;
      chk("done_flag", done, 1);
      chk("done_res_min", res_min, mc);
      chk("done_res_cnt", res_cnt, mm);
      chk("done_jam_rst", jam_rst, 1);
      chk("done_ld_ready", ld_ready, 0);
      chk("done_cost", Cost, 0);
`ifdef JAM_LOOKUP_CNT_EN
      chk("done_lookup_cnt", lookup_cnt, m_run);
`endif
      Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'($urandom);
      ld_valid = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      Valid = 1'b0; ld_valid = 1'b0;
      #1;
      chk("late_valid_res_min", res_min, mc);
      chk("late_valid_res_cnt", res_cnt, mm);
      chk("late_valid_done", done, 1);
      chk("late_valid_jam_rst", jam_rst, 1);
`ifdef JAM_LOOKUP_CNT_EN
      chk("frozen_lookup_cnt", lookup_cnt, m_run);
`endif
   endtask

   initial begin
      RST = 1'b1; ld_valid = 1'b0; ld_data = '0; Valid = 1'b0;
      W = '0; J = '0; MinCost = '0; MatchCount = '0;
      do_reset();

      load_table(0);
      run_lookups(30);
      fire_valid(10'($urandom), 4'($urandom));

      do_reset();
      load_table(1);
      lookup_exp(3'd3, 3'd5, 29);
      lookup_exp(3'd7, 3'd7, 63);
      lookup_exp(3'd0, 3'd0, 0);
      lookup_exp(3'd6, 3'd1, 49);
      run_lookups(10);
      fire_valid(10'd312, 4'd3);

      do_reset();
      partial_load(20);
      do_reset();
      load_table(2);
      run_lookups(99);
      fire_valid(10'($urandom), 4'($urandom));
`ifdef JAM_LOOKUP_CNT_EN
      chk("lookup_cnt_100", lookup_cnt, 100);
`endif

      do_reset();
      load_table(2);
      run_lookups(5);
      do_reset();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
